fruit_rom_arbiter: RTL and testbench

Shares one single-port fruit-template ROM (2048 x 8, synchronous read) between several feature-matching requesters. Each requester posts a burst (start address, length), and the arbiter grants bursts round-robin. It drives the ROM address, then returns the read data tagged to the owning requester. The block sits between the per-fruit template ROMs and the recognition/matching engines, so each template is stored once and read by any engine.

---
 rtl/fruit_rom_arbiter.sv | 136 +++++++++++++
 tb/tb_fruit_rom_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fruit_rom_arbiter.sv
// Round-robin burst arbiter that shares one synchronous-read template ROM between
// NREQ matching engines and returns each read word tagged to the owning requester.
module fruit_rom_arbiter #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 8,
   parameter int NREQ       = 3,
   parameter int RD_LATENCY = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NREQ-1:0]            req,
   input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NREQ*ADDR_WIDTH-1:0] req_len,
   output logic [NREQ-1:0]            req_ack,
   output logic [NREQ-1:0]            rd_valid,
   output logic [DATA_WIDTH-1:0]      rd_data,
   output logic                       rd_last,
   output logic                       busy,
   output logic [ADDR_WIDTH-1:0]      rom_addr,
   input  logic [DATA_WIDTH-1:0]      rom_rd_data
);

   localparam int IW = $clog2(NREQ);
   localparam int DW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] BURST = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]                       state;
   logic [IW-1:0]                    last_grant;
   logic [IW-1:0]                    pick;
   logic [IW-1:0]                    cand;
   logic                             found;
   logic [ADDR_WIDTH-1:0]            sel_addr;
   logic [ADDR_WIDTH-1:0]            sel_len;
   logic [NREQ-1:0]                  owner_oh;
   logic [ADDR_WIDTH-1:0]            cnt;
   logic [DW-1:0]                    drain_cnt;
   logic [NREQ-1:0]                  issue_vec;
   logic                             issue_last;
   logic [RD_LATENCY-1:0][NREQ-1:0]  pipe_valid;
   logic [RD_LATENCY-1:0]            pipe_last;

   // Search upward from the previous winner so no requester can be starved.
   always_comb begin
      int idx;
      found    = 1'b0;
      pick     = '0;
      cand     = '0;
      idx      = 0;
      sel_addr = '0;
      sel_len  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = int'(last_grant) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         cand = IW'(idx);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (pick == IW'(i)) begin
            sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_len  = req_len[i*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
   end

   always_comb begin
      issue_vec  = (state == BURST) ? owner_oh : '0;
      issue_last = (state == BURST) && (cnt == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= IW'(NREQ-1);
         owner_oh   <= '0;
         rom_addr   <= '0;
         cnt        <= '0;
         drain_cnt  <= '0;
         req_ack    <= '0;
      end else begin
         req_ack <= '0;
         case (state)
            IDLE: begin
               if (found) begin
                  state      <= BURST;
                  last_grant <= pick;
                  owner_oh   <= NREQ'(1) << pick;
                  req_ack    <= NREQ'(1) << pick;
                  rom_addr   <= sel_addr;
                  cnt        <= sel_len;
               end
            end
            BURST: begin
               if (cnt == '0) begin
                  state     <= DRAIN;
                  drain_cnt <= DW'(RD_LATENCY-1);
               end else begin
                  rom_addr <= rom_addr + ADDR_WIDTH'(1);
                  cnt      <= cnt - ADDR_WIDTH'(1);
               end
            end
            DRAIN: begin
               if (drain_cnt == '0) state <= IDLE;
               else drain_cnt <= drain_cnt - DW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Issue tags travel alongside the ROM's own read latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_valid <= '0;
         pipe_last  <= '0;
      end else begin
         pipe_valid[0] <= issue_vec;
         pipe_last[0]  <= issue_last;
         for (int s = 1; s < RD_LATENCY; s++) begin
            pipe_valid[s] <= pipe_valid[s-1];
            pipe_last[s]  <= pipe_last[s-1];
         end
      end
   end

   assign rd_valid = pipe_valid[RD_LATENCY-1];
   assign rd_last  = pipe_last[RD_LATENCY-1];
   assign rd_data  = rom_rd_data;
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_fruit_rom_arbiter.sv
// Bench for fruit_rom_arbiter: a latency-1 and a latency-2 instance are driven by
// requester models and compared every cycle against a burst timeline model.
module tb_fruit_rom_arbiter;

   localparam int AW   = 11;
   localparam int DWD  = 8;
   localparam int NREQ = 3;
   localparam int MAXC = 4096;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NREQ-1:0]    req [2];
   logic [NREQ*AW-1:0] req_addr [2];
   logic [NREQ*AW-1:0] req_len [2];
   logic [NREQ-1:0]    req_ack [2];
   logic [NREQ-1:0]    rd_valid [2];
   logic [DWD-1:0]     rd_data [2];
   logic [DWD-1:0]     rom_rd_data [2];
   logic [DWD-1:0]     rom_q1 [2];
   logic [DWD-1:0]     rom_q2 [2];
   logic               rd_last [2];
   logic               busy [2];
   logic [AW-1:0]      rom_addr [2];

   fruit_rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DWD), .NREQ(NREQ), .RD_LATENCY(1)) dut_l1 (
      .clk(clk), .rst_n(rst_n), .req(req[0]), .req_addr(req_addr[0]), .req_len(req_len[0]),
      .req_ack(req_ack[0]), .rd_valid(rd_valid[0]), .rd_data(rd_data[0]), .rd_last(rd_last[0]),
      .busy(busy[0]), .rom_addr(rom_addr[0]), .rom_rd_data(rom_rd_data[0]));

   fruit_rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DWD), .NREQ(NREQ), .RD_LATENCY(2)) dut_l2 (
      .clk(clk), .rst_n(rst_n), .req(req[1]), .req_addr(req_addr[1]), .req_len(req_len[1]),
      .req_ack(req_ack[1]), .rd_valid(rd_valid[1]), .rd_data(rd_data[1]), .rd_last(rd_last[1]),
      .busy(busy[1]), .rom_addr(rom_addr[1]), .rom_rd_data(rom_rd_data[1]));

   // ROM contents are data[a] = a[7:0]; the latency-2 instance sees an extra output register.
   always @(posedge clk) begin
      for (int u = 0; u < 2; u++) begin
         rom_q1[u] <= rom_addr[u][7:0];
         rom_q2[u] <= rom_q1[u];
      end
   end
   assign rom_rd_data[0] = rom_q1[0];
   assign rom_rd_data[1] = rom_q2[1];

   logic [NREQ-1:0] e_ack   [2][MAXC];
   logic [NREQ-1:0] e_valid [2][MAXC];
   logic            e_last  [2][MAXC];
   logic            e_busy  [2][MAXC];
   logic [7:0]      e_data  [2][MAXC];
   int              e_raddr [2][MAXC];
   int              idle_edge [2];
   int              rr [2];
   bit              pend  [2][NREQ];
   int              paddr [2][NREQ];
   int              plen  [2][NREQ];
   int              cyc;
   int              mode;
   int              n_cmp;
   int              n_err;
   int              valid_count [2];
   int              last_count [2];
   int              ack_log [$];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_err++;
         $display("[TB] FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", tag, cyc, obs, expv);
      end
   endtask

   task automatic clearModel();
      for (int u = 0; u < 2; u++) begin
         for (int c = 0; c < MAXC; c++) begin
            e_ack[u][c]   = '0;
            e_valid[u][c] = '0;
            e_last[u][c]  = 1'b0;
            e_busy[u][c]  = 1'b0;
            e_data[u][c]  = '0;
            e_raddr[u][c] = -1;
         end
         for (int i = 0; i < NREQ; i++) begin
            pend[u][i]  = 1'b0;
            paddr[u][i] = 0;
            plen[u][i]  = 0;
         end
         idle_edge[u]   = 0;
         rr[u]          = NREQ - 1;
         valid_count[u] = 0;
         last_count[u]  = 0;
         req[u]         = '0;
         req_addr[u]    = '0;
         req_len[u]     = '0;
      end
      ack_log.delete();
   endtask

   task automatic post(input int i, input int a, input int l);
      for (int u = 0; u < 2; u++) begin
         pend[u][i]  = 1'b1;
         paddr[u][i] = a;
         plen[u][i]  = l;
      end
   endtask

   // Drives the requesters and, if the arbiter is free at the next edge, schedules
   // the whole burst timeline that edge must produce.
   task automatic applyStimulus();
      for (int u = 0; u < 2; u++) begin
         logic [NREQ-1:0] rv;
         int n, w, a, l, lat;
         rv = '0;
         for (int i = 0; i < NREQ; i++) begin
            rv[i] = pend[u][i];
            req_addr[u][i*AW +: AW] = AW'(paddr[u][i]);
            req_len[u][i*AW +: AW]  = AW'(plen[u][i]);
         end
         req[u] = rv;
         n   = cyc + 1;
         lat = u + 1;
         if (n >= idle_edge[u] && rv != '0) begin
            w = -1;
            for (int k = 1; k <= NREQ; k++)
               if (w < 0 && pend[u][(rr[u] + k) % NREQ]) w = (rr[u] + k) % NREQ;
            a = paddr[u][w];
            l = plen[u][w];
            if (n + l + lat + 2 >= MAXC) begin
               $display("[TB] FAIL timeline overflow at cycle %0d", cyc);
               $fatal(1, "[TB] timeline table too small");
            end
            e_ack[u][n] = NREQ'(1) << w;
            for (int j = 0; j <= l; j++) begin
               e_raddr[u][n+j]     = (a + j) % 2048;
               e_valid[u][n+j+lat] = NREQ'(1) << w;
               e_data[u][n+j+lat]  = 8'((a + j) % 256);
               e_last[u][n+j+lat]  = (j == l);
            end
            for (int t = n; t <= n + l + lat; t++) e_busy[u][t] = 1'b1;
            idle_edge[u] = n + l + lat + 2;
            rr[u] = w;
         end
      end
   endtask

   task automatic checkCycle();
      for (int u = 0; u < 2; u++) begin
         string p;
         p = (u == 0) ? "l1" : "l2";
         checkOutput({p, "_ack"},   32'(req_ack[u]),  32'(e_ack[u][cyc]));
         checkOutput({p, "_valid"}, 32'(rd_valid[u]), 32'(e_valid[u][cyc]));
         checkOutput({p, "_last"},  32'(rd_last[u]),  32'(e_last[u][cyc]));
         checkOutput({p, "_busy"},  32'(busy[u]),     32'(e_busy[u][cyc]));
         checkOutput({p, "_onehot"}, 32'($onehot0(rd_valid[u])), 32'd1);
         if (e_valid[u][cyc] != '0) checkOutput({p, "_data"}, 32'(rd_data[u]), 32'(e_data[u][cyc]));
         if (e_raddr[u][cyc] >= 0)  checkOutput({p, "_rom_addr"}, 32'(rom_addr[u]), 32'(e_raddr[u][cyc]));
         if (rd_valid[u] != '0) valid_count[u]++;
         if (rd_last[u]) last_count[u]++;
      end
      for (int i = 0; i < NREQ; i++) if (req_ack[0][i]) ack_log.push_back(i);
   endtask

   // Requesters re-arm first and drop on acknowledge, so a dropped req stays low one edge.
   task automatic updateRequesters();
      for (int u = 0; u < 2; u++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[u][i] && mode == 1) begin
               pend[u][i]  = 1'b1;
               paddr[u][i] = int'($urandom_range(0, 2047));
               plen[u][i]  = 0;
            end else if (!pend[u][i] && mode == 2 && cyc < 2500 && $urandom_range(0, 3) == 0) begin
               pend[u][i]  = 1'b1;
               paddr[u][i] = int'($urandom_range(0, 2047));
               plen[u][i]  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 5));
            end
         end
         for (int i = 0; i < NREQ; i++) if (e_ack[u][cyc][i]) pend[u][i] = 1'b0;
      end
   endtask

   task automatic runCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         checkCycle();
         updateRequesters();
         applyStimulus();
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      for (int u = 0; u < 2; u++) begin
         checkOutput("rst_ack",      32'(req_ack[u]),  32'd0);
         checkOutput("rst_valid",    32'(rd_valid[u]), 32'd0);
         checkOutput("rst_last",     32'(rd_last[u]),  32'd0);
         checkOutput("rst_busy",     32'(busy[u]),     32'd0);
         checkOutput("rst_rom_addr", 32'(rom_addr[u]), 32'd0);
      end
      clearModel();
      repeat (3) @(negedge clk);
      for (int u = 0; u < 2; u++) checkOutput("rst_hold_last", 32'(rd_last[u]), 32'd0);
      rst_n = 1'b1;
      cyc = 0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      cyc   = 0;
      mode  = 0;
      clearModel();

      $display("[TB] single burst, addr 0x010 len 3");
      doReset();
      post(0, 'h010, 3);
      applyStimulus();
      runCycles(12);

      $display("[TB] wrap-around burst, addr 0x7FE len 3");
      doReset();
      post(1, 'h7FE, 3);
      applyStimulus();
      runCycles(12);

      $display("[TB] single-word burst, addr 5 len 0");
      doReset();
      post(2, 5, 0);
      applyStimulus();
      runCycles(8);

      $display("[TB] round-robin fairness");
      doReset();
      mode = 1;
      for (int i = 0; i < NREQ; i++) post(i, int'($urandom_range(0, 2047)), 0);
      applyStimulus();
      runCycles(30);
      checkOutput("rr_count", 32'(ack_log.size() >= 6), 32'd1);
      for (int i = 0; i < 6 && i < ack_log.size(); i++) checkOutput("rr_order", 32'(ack_log[i]), 32'(i % 3));

      $display("[TB] full ROM burst");
      doReset();
      mode = 0;
      post(0, 0, 2047);
      applyStimulus();
      runCycles(2060);
      for (int u = 0; u < 2; u++) begin
         checkOutput("full_valid_cycles", 32'(valid_count[u]), 32'd2048);
         checkOutput("full_last_count",   32'(last_count[u]),  32'd1);
      end

      $display("[TB] randomized requesters");
      doReset();
      mode = 2;
      applyStimulus();
      runCycles(2700);

      $display("[TB] reset in the middle of a burst");
      doReset();
      mode = 0;
      post(0, 'h100, 10);
      applyStimulus();
      runCycles(4);
      doReset();
      for (int i = NREQ - 1; i >= 0; i--) post(i, 'h200 + i * 16, 2);
      applyStimulus();
      runCycles(25);
      checkOutput("post_reset_grants", 32'(ack_log.size() >= 1), 32'd1);
      if (ack_log.size() >= 1) checkOutput("post_reset_first", 32'(ack_log[0]), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
